// File: rtl/register_file_mrnw_if.sv
// register_file_mrnw_if: read, write and scoreboard signals of the
// multi-port register file. The master side is decode/issue plus writeback;
// the slave side is the register file itself.
interface register_file_mrnw_if #(
  parameter int SIZE   = 16,
  parameter int WIDTH  = 32,
  parameter int NUM_RD = 3,
  parameter int NUM_WR = 2
);
  localparam int AW = (SIZE > 2) ? $clog2(SIZE) : 1;

  logic [NUM_RD*AW-1:0]    rd_addr;
  logic [NUM_RD*WIDTH-1:0] rd_data;
  logic [NUM_RD-1:0]       rd_pend;
  logic [NUM_WR-1:0]       wr_en;
  logic [NUM_WR*AW-1:0]    wr_addr;
  logic [NUM_WR*WIDTH-1:0] wr_data;
  logic                    sb_set_en;
  logic [AW-1:0]           sb_set_addr;
  logic                    init_busy;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, sb_set_en, sb_set_addr,
    input  rd_data, rd_pend, init_busy
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, sb_set_en, sb_set_addr,
    output rd_data, rd_pend, init_busy
  );
endinterface

// File: rtl/register_file_mrnw.sv
// register_file_mrnw: parametrised multi-read/multi-write register file with
// per-register pending bits, same-cycle write-to-read bypass, optional
// hardwired zero register and a post-reset sweep that zeroes the array.
//
// state | meaning
// CLEAR | sweeping mem/pend to zero, one entry per cycle; ports masked
// READY | normal reads, writes and scoreboard updates
module register_file_mrnw #(
  parameter int SIZE     = 16,
  parameter int WIDTH    = 32,
  parameter int NUM_RD   = 3,
  parameter int NUM_WR   = 2,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input logic                 clk,
  input logic                 rst,
  register_file_mrnw_if.slave bus
);
  localparam int AW = (SIZE > 2) ? $clog2(SIZE) : 1;

  typedef enum logic {CLEAR, READY} state_t;

  state_t           state, state_nxt;
  logic [AW-1:0]    cnt, cnt_nxt;
  logic [WIDTH-1:0] mem [SIZE];
  logic [SIZE-1:0]  pend;
  logic             active;

  function automatic logic in_range(input logic [AW-1:0] a);
    return int'(a) < SIZE;
  endfunction

  // Register 0 is read-only when hardwired to zero.
  function automatic logic writable(input logic [AW-1:0] a);
    return in_range(a) && !(ZERO_REG && a == '0);
  endfunction

  assign active        = (state == READY) && !rst;
  assign bus.init_busy = rst || (state == CLEAR);

  // State and sweep pointer; reset always restarts the sweep at entry 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Advance the sweep pointer and leave CLEAR once the last entry is zeroed.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      CLEAR: begin
        if (int'(cnt) == SIZE - 1) begin
          state_nxt = READY;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + AW'(1);
        end
      end
      default: state_nxt = state;
    endcase
  end

  // Array and pending bits: sweep in CLEAR, ports and scoreboard in READY.
  // Later loop iterations override earlier ones, so the highest write port
  // wins a same-address conflict and a scoreboard set beats a write clear.
  always_ff @(posedge clk) begin
    if (!rst && state == CLEAR) begin
      mem[cnt]  <= '0;
      pend[cnt] <= 1'b0;
    end else if (active) begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (bus.wr_en[j] && writable(bus.wr_addr[j*AW +: AW])) begin
          mem[bus.wr_addr[j*AW +: AW]]  <= bus.wr_data[j*WIDTH +: WIDTH];
          pend[bus.wr_addr[j*AW +: AW]] <= 1'b0;
        end
      end
      if (bus.sb_set_en && writable(bus.sb_set_addr)) begin
        pend[bus.sb_set_addr] <= 1'b1;
      end
    end
  end

  // Combinational read ports; the zero register and out-of-range addresses
  // stay at the zero default, so they take precedence over bypass.
  always_comb begin
    bus.rd_data = '0;
    bus.rd_pend = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      logic [AW-1:0] a;
      a = bus.rd_addr[i*AW +: AW];
      if (active && in_range(a) && !(ZERO_REG && a == '0)) begin
        bus.rd_data[i*WIDTH +: WIDTH] = mem[a];
        bus.rd_pend[i]                = pend[a];
        if (BYPASS) begin
          for (int j = 0; j < NUM_WR; j++) begin
            if (bus.wr_en[j] && bus.wr_addr[j*AW +: AW] == a) begin
              bus.rd_data[i*WIDTH +: WIDTH] = bus.wr_data[j*WIDTH +: WIDTH];
              bus.rd_pend[i]                = 1'b0;
            end
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_register_file_mrnw.sv
// tb_register_file_mrnw: two register files side by side, a default one
// (16 x 32, 3R/2W, bypass on) and a generic one (12 x 32, 4R/1W, bypass off),
// checked every cycle against an array-level reference model, plus a vector
// table and directed sequences for reset, clear and corner cases.
module tb_register_file_mrnw;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [3:0]  ra  [2][4];
  logic        we  [2][2];
  logic [3:0]  wa  [2][2];
  logic [31:0] wd  [2][2];
  logic        sbe [2];
  logic [3:0]  sba [2];
  logic [31:0] od  [2][4];
  logic        op  [2][4];
  logic        ob  [2];

  register_file_mrnw_if #(.SIZE(16), .WIDTH(32), .NUM_RD(3), .NUM_WR(2)) ifa ();
  register_file_mrnw_if #(.SIZE(12), .WIDTH(32), .NUM_RD(4), .NUM_WR(1)) ifb ();

  register_file_mrnw #(.SIZE(16), .WIDTH(32), .NUM_RD(3), .NUM_WR(2),
                       .ZERO_REG(1'b1), .BYPASS(1'b1))
    dut_a (.clk(clk), .rst(rst), .bus(ifa));
  register_file_mrnw #(.SIZE(12), .WIDTH(32), .NUM_RD(4), .NUM_WR(1),
                       .ZERO_REG(1'b1), .BYPASS(1'b0))
    dut_b (.clk(clk), .rst(rst), .bus(ifb));

  assign ifa.rd_addr     = {ra[0][2], ra[0][1], ra[0][0]};
  assign ifa.wr_en       = {we[0][1], we[0][0]};
  assign ifa.wr_addr     = {wa[0][1], wa[0][0]};
  assign ifa.wr_data     = {wd[0][1], wd[0][0]};
  assign ifa.sb_set_en   = sbe[0];
  assign ifa.sb_set_addr = sba[0];
  assign ifb.rd_addr     = {ra[1][3], ra[1][2], ra[1][1], ra[1][0]};
  assign ifb.wr_en       = we[1][0];
  assign ifb.wr_addr     = wa[1][0];
  assign ifb.wr_data     = wd[1][0];
  assign ifb.sb_set_en   = sbe[1];
  assign ifb.sb_set_addr = sba[1];

  assign od[0][0] = ifa.rd_data[31:0];
  assign od[0][1] = ifa.rd_data[63:32];
  assign od[0][2] = ifa.rd_data[95:64];
  assign od[0][3] = '0;
  assign od[1][0] = ifb.rd_data[31:0];
  assign od[1][1] = ifb.rd_data[63:32];
  assign od[1][2] = ifb.rd_data[95:64];
  assign od[1][3] = ifb.rd_data[127:96];
  assign op[0][0] = ifa.rd_pend[0];
  assign op[0][1] = ifa.rd_pend[1];
  assign op[0][2] = ifa.rd_pend[2];
  assign op[0][3] = 1'b0;
  assign op[1][0] = ifb.rd_pend[0];
  assign op[1][1] = ifb.rd_pend[1];
  assign op[1][2] = ifb.rd_pend[2];
  assign op[1][3] = ifb.rd_pend[3];
  assign ob[0]    = ifa.init_busy;
  assign ob[1]    = ifb.init_busy;

  // Reference model: register contents, pending flags and remaining clear
  // cycles per design. The clear is modelled as a whole-array wipe when the
  // countdown expires, since nothing is readable while it runs.
  int          sz  [2];
  int          nrd [2];
  int          nwr [2];
  int          byp [2];
  logic [31:0] mm  [2][16];
  bit          mp  [2][16];
  int          rem [2];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          c0, c1;

  typedef struct {
    bit        rst;
    bit [1:0]  we;
    bit [3:0]  wa0;
    bit [31:0] wd0;
    bit [3:0]  wa1;
    bit [31:0] wd1;
    bit        sbe;
    bit [3:0]  sba;
    bit [3:0]  ra;
    bit [31:0] ed;
    bit        ep;
    bit        eb;
  } vec_t;
  localparam int NV = 16;
  vec_t vt [NV];

  task automatic check(input string name, input int d, input int p,
                       input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s dut%0d idx%0d: got %h, want %h", name, d, p, got, want);
    end
  endtask

  function automatic logic [32:0] model_rd(input int d, input int i);
    int          a;
    logic [31:0] v;
    logic        p;
    a = int'(ra[d][i]);
    if (rst || rem[d] > 0 || a >= sz[d] || a == 0) return 33'd0;
    v = mm[d][a];
    p = mp[d][a];
    if (byp[d] != 0) begin
      for (int j = 0; j < nwr[d]; j++) begin
        if (we[d][j] && int'(wa[d][j]) == a) begin
          v = wd[d][j];
          p = 1'b0;
        end
      end
    end
    return {p, v};
  endfunction

  task automatic mcheck();
    logic [32:0] e;
    for (int d = 0; d < 2; d++) begin
      check("busy", d, 0, 32'(ob[d]), 32'(rst || rem[d] > 0));
      for (int i = 0; i < nrd[d]; i++) begin
        e = model_rd(d, i);
        check("rd_data", d, i, od[d][i], e[31:0]);
        check("rd_pend", d, i, 32'(op[d][i]), 32'(e[32]));
      end
    end
  endtask

  task automatic advance();
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        rem[d] = sz[d];
      end else if (rem[d] > 0) begin
        rem[d]--;
        if (rem[d] == 0) begin
          for (int k = 0; k < 16; k++) begin
            mm[d][k] = '0;
            mp[d][k] = 1'b0;
          end
        end
      end else begin
        for (int j = 0; j < nwr[d]; j++) begin
          if (we[d][j] && wa[d][j] != 0 && int'(wa[d][j]) < sz[d]) begin
            mm[d][wa[d][j]] = wd[d][j];
            mp[d][wa[d][j]] = 1'b0;
          end
        end
        if (sbe[d] && sba[d] != 0 && int'(sba[d]) < sz[d]) mp[d][sba[d]] = 1'b1;
      end
    end
    #1;
  endtask

  task automatic cycle();
    @(negedge clk);
    mcheck();
    advance();
  endtask

  task automatic idle();
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      for (int j = 0; j < 2; j++) begin
        we[d][j] = 1'b0;
        wa[d][j] = '0;
        wd[d][j] = '0;
      end
      sbe[d] = 1'b0;
      sba[d] = '0;
    end
  endtask

  task automatic count_busy(output int n0, output int n1);
    n0 = 0;
    n1 = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      mcheck();
      if (ob[0]) n0++;
      if (ob[1]) n1++;
      advance();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    sz  = '{16, 12};
    nrd = '{3, 4};
    nwr = '{2, 1};
    byp = '{1, 0};
    rem = '{0, 0};
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < 16; k++) begin
        mm[d][k] = '0;
        mp[d][k] = 1'b0;
      end
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 4; i++) ra[d][i] = '0;
    idle();

    //        rst we     wa0   wd0            wa1   wd1            sbe sba   ra    ed             ep eb
    vt[0]  = '{0, 2'b01, 4'd5, 32'hDEADBEEF, 4'd0, 32'h0,         0, 4'd0, 4'd5, 32'hDEADBEEF, 0, 0};
    vt[1]  = '{0, 2'b00, 4'd0, 32'h0,        4'd0, 32'h0,         0, 4'd0, 4'd5, 32'hDEADBEEF, 0, 0};
    vt[2]  = '{0, 2'b11, 4'd3, 32'h11111111, 4'd3, 32'h22222222,  0, 4'd0, 4'd3, 32'h22222222, 0, 0};
    vt[3]  = '{0, 2'b00, 4'd0, 32'h0,        4'd0, 32'h0,         0, 4'd0, 4'd3, 32'h22222222, 0, 0};
    vt[4]  = '{0, 2'b11, 4'd0, 32'hFFFFFFFF, 4'd0, 32'hFFFFFFFF,  0, 4'd0, 4'd0, 32'h0,        0, 0};
    vt[5]  = '{0, 2'b00, 4'd0, 32'h0,        4'd0, 32'h0,         0, 4'd0, 4'd0, 32'h0,        0, 0};
    vt[6]  = '{0, 2'b00, 4'd0, 32'h0,        4'd0, 32'h0,         1, 4'd9, 4'd9, 32'h0,        0, 0};
    vt[7]  = '{0, 2'b00, 4'd0, 32'h0,        4'd0, 32'h0,         0, 4'd0, 4'd9, 32'h0,        1, 0};
    vt[8]  = '{0, 2'b01, 4'd9, 32'h5,        4'd0, 32'h0,         0, 4'd0, 4'd9, 32'h5,        0, 0};
    vt[9]  = '{0, 2'b00, 4'd0, 32'h0,        4'd0, 32'h0,         0, 4'd0, 4'd9, 32'h5,        0, 0};
    vt[10] = '{0, 2'b10, 4'd0, 32'h0,        4'd9, 32'h6,         1, 4'd9, 4'd9, 32'h6,        0, 0};
    vt[11] = '{0, 2'b00, 4'd0, 32'h0,        4'd0, 32'h0,         0, 4'd0, 4'd9, 32'h6,        1, 0};
    vt[12] = '{0, 2'b00, 4'd0, 32'h0,        4'd0, 32'h0,         1, 4'd0, 4'd0, 32'h0,        0, 0};
    vt[13] = '{0, 2'b00, 4'd0, 32'h0,        4'd0, 32'h0,         0, 4'd0, 4'd0, 32'h0,        0, 0};
    vt[14] = '{1, 2'b00, 4'd0, 32'h0,        4'd0, 32'h0,         0, 4'd0, 4'd5, 32'h0,        0, 1};
    vt[15] = '{0, 2'b01, 4'd5, 32'h77,       4'd0, 32'h0,         1, 4'd5, 4'd5, 32'h0,        0, 1};

    // Power-up reset, then the clear length of each configuration.
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    count_busy(c0, c1);
    check("busy_len", 0, 0, c0, 16);
    check("busy_len", 1, 0, c1, 12);

    // Vector table on the default design.
    for (int k = 0; k < NV; k++) begin
      rst      = vt[k].rst;
      we[0][0] = vt[k].we[0];
      we[0][1] = vt[k].we[1];
      wa[0][0] = vt[k].wa0;
      wd[0][0] = vt[k].wd0;
      wa[0][1] = vt[k].wa1;
      wd[0][1] = vt[k].wd1;
      sbe[0]   = vt[k].sbe;
      sba[0]   = vt[k].sba;
      for (int i = 0; i < 3; i++) ra[0][i] = vt[k].ra;
      @(negedge clk);
      mcheck();
      for (int i = 0; i < 3; i++) begin
        check("vec_data", 0, k, od[0][i], vt[k].ed);
        check("vec_pend", 0, k, 32'(op[0][i]), 32'(vt[k].ep));
      end
      check("vec_busy", 0, k, 32'(ob[0]), 32'(vt[k].eb));
      advance();
    end

    // After the clear the preloaded r5 and the write attempted in CLEAR are gone.
    idle();
    for (int k = 0; k < 40 && ob[0]; k++) cycle();
    check("ready_timeout", 0, 0, 32'(ob[0]), 32'd0);
    ra[0][0] = 4'd5;
    @(negedge clk);
    mcheck();
    check("clr_r5_data", 0, 0, od[0][0], 32'h0);
    check("clr_r5_pend", 0, 0, 32'(op[0][0]), 32'd0);
    advance();

    // Reset again at clear cycle 8 with writes attempted throughout.
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    we[0][0] = 1'b1; wa[0][0] = 4'd4; wd[0][0] = 32'h1234;
    we[1][0] = 1'b1; wa[1][0] = 4'd4; wd[1][0] = 32'h5678;
    repeat (8) cycle();
    rst = 1'b1;
    cycle();
    idle();
    count_busy(c0, c1);
    check("restart_len", 0, 0, c0, 16);
    check("restart_len", 1, 0, c1, 12);
    ra[0][0] = 4'd4;
    ra[1][0] = 4'd4;
    @(negedge clk);
    mcheck();
    check("clear_wr_r4", 0, 0, od[0][0], 32'h0);
    check("clear_wr_r4", 1, 0, od[1][0], 32'h0);
    advance();

    // Generic design: no bypass, so the write shows only on the next cycle.
    we[1][0] = 1'b1; wa[1][0] = 4'd7; wd[1][0] = 32'hA5A5A5A5;
    ra[1][0] = 4'd7;
    @(negedge clk);
    mcheck();
    check("nobyp_same", 1, 0, od[1][0], 32'h0);
    advance();
    idle();
    @(negedge clk);
    mcheck();
    check("nobyp_next", 1, 0, od[1][0], 32'hA5A5A5A5);
    advance();

    // Zero register ignores writes on every read port.
    we[1][0] = 1'b1; wa[1][0] = 4'd0; wd[1][0] = 32'hFFFFFFFF;
    for (int i = 0; i < 4; i++) ra[1][i] = 4'd0;
    cycle();
    idle();
    @(negedge clk);
    mcheck();
    for (int i = 0; i < 4; i++) check("zero_reg", 1, i, od[1][i], 32'h0);
    advance();

    // Out-of-range write must not land anywhere, including an aliased entry.
    we[1][0] = 1'b1; wa[1][0] = 4'd14; wd[1][0] = 32'hCAFEF00D;
    sbe[1] = 1'b1; sba[1] = 4'd13;
    ra[1][0] = 4'd13;
    @(negedge clk);
    mcheck();
    check("oor_rd13", 1, 0, od[1][0], 32'h0);
    advance();
    idle();
    ra[1][0] = 4'd14; ra[1][1] = 4'd2; ra[1][2] = 4'd13; ra[1][3] = 4'd1;
    @(negedge clk);
    mcheck();
    check("oor_rd14", 1, 0, od[1][0], 32'h0);
    check("oor_alias", 1, 1, od[1][1], 32'h0);
    check("oor_pend13", 1, 2, 32'(op[1][2]), 32'd0);
    advance();

    // Four independent read ports.
    for (int k = 1; k <= 4; k++) begin
      we[1][0] = 1'b1; wa[1][0] = 4'(k); wd[1][0] = 32'h100 + 32'(k);
      cycle();
    end
    idle();
    for (int i = 0; i < 4; i++) ra[1][i] = 4'(4 - i);
    @(negedge clk);
    mcheck();
    for (int i = 0; i < 4; i++) check("indep_port", 1, i, od[1][i], 32'h100 + 32'(4 - i));
    advance();

    // Randomised traffic against the model, with occasional resets.
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 63) == 0);
      for (int d = 0; d < 2; d++) begin
        for (int j = 0; j < 2; j++) begin
          we[d][j] = 1'($urandom_range(0, 1));
          wa[d][j] = 4'($urandom_range(0, 15));
          wd[d][j] = $urandom;
        end
        sbe[d] = ($urandom_range(0, 2) == 0);
        sba[d] = ($urandom_range(0, 1) == 1) ? wa[d][0] : 4'($urandom_range(0, 15));
        for (int i = 0; i < 4; i++)
          ra[d][i] = ($urandom_range(0, 1) == 1) ? wa[d][$urandom_range(0, 1)]
                                                 : 4'($urandom_range(0, 15));
      end
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/register_file_mrnw.md
Name: register_file_mrnw

Overview:
- Parametrised successor to the fixed 3-read/2-write register file used by the vcpu32 core.
- Configurable read-port count, write-port count, depth and width.
- Adds per-register pending (scoreboard) bits, same-cycle write-to-read bypass, an optional hardwired zero register, and a post-reset clear sequencer that zeroes the array one entry per cycle.
- Sits between decode/issue (reads, scoreboard set) and writeback (writes, scoreboard clear).

Parameters:
- SIZE, 16: number of registers; any value ≥ 2, not necessarily a power of 2.
- WIDTH, 32: data width (`WORD_LENGTH` at the top level).
- NUM_RD, 3: read ports, 1..8.
- NUM_WR, 2: write ports, 1..4.
- ZERO_REG, 1: when 1, register 0 always reads 0, ignores writes, and never becomes pending.
- BYPASS, 1: when 1, a same-cycle write is forwarded to matching reads.
- Localparam AW = $clog2(SIZE), minimum 1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- rd_addr  in  NUM_RD*AW  read addresses; port i occupies bits [i*AW +: AW].
- rd_data  out  NUM_RD*WIDTH  read data, combinational.
- rd_pend  out  NUM_RD  pending status of each read address, combinational.
- wr_en  in  NUM_WR  per-port write enables.
- wr_addr  in  NUM_WR*AW  write addresses.
- wr_data  in  NUM_WR*WIDTH  write data.
- sb_set_en  in  1  mark a register pending (new producer issued).
- sb_set_addr  in  AW  register to mark pending.
- init_busy  out  1  high while the clear sequencer runs.

Behaviour:
- **State machine:** states CLEAR and READY.
  - Any cycle with rst=1 sets state to CLEAR and cnt to 0 at the next edge. This applies in any state, including mid-clear, which restarts the sequence at 0.
  - In CLEAR with rst=0: each edge writes mem[cnt]=0 and pend[cnt]=0, then increments cnt. When cnt reaches SIZE-1 and that entry is cleared, state becomes READY.
  - After rst deasserts, init_busy stays high for exactly SIZE cycles, then drops.
- **Outputs during reset and CLEAR:**
  - init_busy=1.
  - rd_data=0 and rd_pend=0 on all ports.
  - wr_en and sb_set_en are ignored.
- **Reads (READY), asynchronous:**
  - rd_data[i] = mem[rd_addr[i]], subject to the overrides below.
  - Bypass: if BYPASS=1 and some wr_en[j] has wr_addr[j]==rd_addr[i] this cycle, return wr_data[j]. If several ports match, the highest j wins.
  - Zero register: if ZERO_REG=1 and rd_addr[i]==0, return 0. This overrides bypass.
  - Out of range: rd_addr ≥ SIZE returns rd_data=0 and rd_pend=0.
- **Writes (READY):**
  - Each enabled port writes mem[wr_addr] at the edge, so the new value is visible to a non-bypassed read the next cycle.
  - If several ports write the same address in one cycle, the highest port index wins.
  - Writes with address ≥ SIZE are ignored. Writes to address 0 are ignored when ZERO_REG=1.
- **Scoreboard (READY):**
  - sb_set_en sets pend[sb_set_addr] at the edge.
  - Each enabled write clears pend[wr_addr] at the edge.
  - Same address set and cleared in the same cycle: the set wins and pend ends at 1.
  - sb_set_en with address 0 (when ZERO_REG=1) or address ≥ SIZE is ignored.
  - rd_pend[i] = pend[rd_addr[i]]. When BYPASS=1, a same-cycle write to that address forces rd_pend[i]=0.
- **Reset mid-operation:** writes and scoreboard sets in a cycle with rst=1 are discarded.

Test Plan:
- Reset and clear: preload mem[5]=0xDEADBEEF, pulse rst for 1 cycle. Expect init_busy high for exactly 16 cycles, reads of register 5 return 0 during that time, and after READY reg 5 reads 0x00000000 with rd_pend=0.
- Write conflict: in one cycle, wr port0 writes r3=0x11111111 and port1 writes r3=0x22222222. With BYPASS=1, expect rd_data for r3 =0x22222222 in the same cycle and on the following cycle.
- Bypass off and zero register: with BYPASS=0, write r7=0xA5A5A5A5. Expect the old value 0 the same cycle and 0xA5A5A5A5 next cycle. Then write r0=0xFFFFFFFF and expect rd_data for r0 to be 0 on all ports.
- Scoreboard: sb_set r9, then expect rd_pend=1 the next cycle. Write r9=0x5 and expect rd_pend=0 in the same cycle (bypass). Set and write r9 in the same cycle, and expect rd_pend=1 afterwards.
- Reset mid-clear: assert rst at clear cycle 8. Expect cnt to restart and init_busy to stay high for 16 more cycles after deassertion. Writes attempted during CLEAR have no effect.
- Generic configuration (SIZE=12, NUM_RD=4, NUM_WR=1): a read at address 13 returns 0 and a write to address 14 is ignored. The clear takes 12 cycles, and all 4 read ports return independent values.
